// File: rtl/atc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atc_pkg                                                               |
// | Shared state and grant-mode encodings for the runway slot decoder.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package atc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_GUARD_GAP = 2'd2
    } state_t;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERMO = 1'b1;

endpackage
`default_nettype wire

// File: rtl/slot_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slot_pattern_gen                                                      |
// | Combinational one-hot / thermometer decode of a slot selector.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module slot_pattern_gen
    import atc_pkg::*;
#(
    parameter int SEL_W    = 4,
    parameter int NUM_OUTS = 12
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    output logic [NUM_OUTS-1:0] pattern
);

    for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_bit
        localparam logic [SEL_W-1:0] c_IDX = SEL_W'(gi);
        assign pattern[gi] = (mode == MODE_THERMO) ? (sel >= c_IDX) : (sel == c_IDX);
    end

endmodule
`default_nettype wire

// File: rtl/runway_slot_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | runway_slot_decoder                                                   |
// | Grants a decoded slot pattern for HOLD cycles, then a GUARD gap.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module runway_slot_decoder
    import atc_pkg::*;
#(
    parameter int SEL_W    = 4,
    parameter int NUM_OUTS = 12,
    parameter int HOLD     = 8,
    parameter int GUARD    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SEL_W-1:0]    req_sel,
    input  logic                req_mode,
    input  logic                abort,
    output logic [NUM_OUTS-1:0] grant,
    output logic                grant_valid,
    output logic                err,
    output logic                busy
);

    localparam int c_MAX_CNT = (HOLD > GUARD) ? HOLD : GUARD;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD  = c_CNT_W'(HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LOAD = c_CNT_W'((GUARD > 0) ? GUARD - 1 : 0);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [NUM_OUTS-1:0] r_grant;
    logic                r_grant_valid;
    logic                r_err;
    logic                r_busy;

    logic [NUM_OUTS-1:0] w_pattern;
    logic                w_accept;
    logic                w_sel_ok;

    slot_pattern_gen #(
        .SEL_W    (SEL_W),
        .NUM_OUTS (NUM_OUTS)
    ) u_pattern (
        .sel     (req_sel),
        .mode    (req_mode),
        .pattern (w_pattern)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_sel_ok  = (int'(req_sel) < NUM_OUTS);

    // The counter holds "cycles remaining minus one" so the last cycle of a
    // phase is the one where it reads zero; it is never decremented from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_sel_ok) begin
                            r_state       <= ST_ACTIVE;
                            r_cnt         <= c_HOLD_LOAD;
                            r_grant       <= w_pattern;
                            r_grant_valid <= 1'b1;
                            r_busy        <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (abort || (r_cnt == '0)) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        if (GUARD > 0) begin
                            r_state <= ST_GUARD_GAP;
                            r_cnt   <= c_GUARD_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                ST_GUARD_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_cnt         <= '0;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign err         = r_err;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/runway_slot_decoder.md
RUNWAY_SLOT_DECODER -- requirements
Module: runway_slot_decoder

Interface
REQ-001 Parameter SEL_W, default 4: selector width in bits.
REQ-002 Parameter NUM_OUTS, default 12: number of implemented outputs; legal range 1..2**SEL_W.
REQ-003 Parameter HOLD, default 8: cycles a grant stays asserted; legal range >= 1.
REQ-004 Parameter GUARD, default 2: all-zero cycles after each grant; legal range >= 0.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_sel  input  SEL_W  requested slot index.
REQ-010 req_mode  input  1  0 = one-hot grant, 1 = thermometer grant (bits 0..sel set).
REQ-011 abort  input  1  cancel the current grant.
REQ-012 grant  output  NUM_OUTS  registered decoded slot lines.
REQ-013 grant_valid  output  1  high while grant is driven, i.e. in ACTIVE.
REQ-014 err  output  1  one-cycle pulse when a request has an out-of-range selector.
REQ-015 busy  output  1  high in ACTIVE or GUARD_GAP.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACTIVE, GUARD_GAP.
REQ-017 req_ready SHALL equal (state == IDLE); a request is accepted on a clock edge where req_valid and req_ready are both high.
REQ-018 On acceptance with req_sel < NUM_OUTS, the next cycle SHALL be ACTIVE, with grant set to the decoded pattern for req_sel and req_mode, captured at acceptance.
REQ-019 grant SHALL stay constant for exactly HOLD cycles in ACTIVE, then become all-zero.
REQ-020 When HOLD ends and GUARD > 0, the FSM SHALL enter GUARD_GAP for exactly GUARD cycles, then go to IDLE.
REQ-021 When HOLD ends and GUARD == 0, the FSM SHALL go directly to IDLE.
REQ-022 On acceptance with req_sel >= NUM_OUTS, the handshake SHALL complete, err SHALL pulse high in the next cycle, the FSM SHALL stay in IDLE, and grant SHALL stay zero.
REQ-023 abort in ACTIVE SHALL zero grant on the next cycle and enter GUARD_GAP, or IDLE if GUARD == 0, with a full GUARD count.
REQ-024 abort on the last HOLD cycle SHALL behave identically to normal expiry.
REQ-025 abort outside ACTIVE SHALL be ignored.
REQ-026 In thermometer mode, grant bits 0..req_sel SHALL be 1 and all others 0.
REQ-027 In one-hot mode, only bit req_sel of grant SHALL be 1.
REQ-028 The minimum spacing between two accepted requests SHALL be HOLD + GUARD + 1 cycles.
REQ-029 The single down-counter SHALL be clog2(max(HOLD, GUARD) + 1) bits wide and SHALL never wrap below zero.
REQ-030 All outputs SHALL be registered except req_ready, which is decoded directly from the state register.

Reset
REQ-031 While rst_n is low, the state SHALL be IDLE, the counter 0, and grant, grant_valid, err and busy 0; req_ready SHALL be 1 once reset is released.
REQ-032 Reset asserted mid-grant SHALL clear grant immediately, asynchronously, with no guard gap.
REQ-033 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-034 The state encoding enum and the mode encoding constants (MODE_ONEHOT = 0, MODE_THERMO = 1) SHALL live in a shared package, atc_pkg.
REQ-035 The combinational pattern generator SHALL be one sub-module, slot_pattern_gen, with inputs sel and mode, output pattern, and parameters SEL_W and NUM_OUTS; the FSM and counter SHALL reside in the top module.

Verification
REQ-036 Bench SHALL cover: defaults, sel=5, mode=0 accepted -> grant=12'h020 for 8 cycles, 2 zero cycles, req_ready high again on cycle 11 after acceptance.
REQ-037 Bench SHALL cover: sel=3, mode=1 -> grant=12'h00F for 8 cycles.
REQ-038 Bench SHALL cover: sel=13 (>= NUM_OUTS) -> err high for 1 cycle, grant stays 0, req_ready stays 1.
REQ-039 Bench SHALL cover: abort on the 3rd ACTIVE cycle -> grant 0 next cycle, busy for 2 further cycles, then IDLE.
REQ-040 Bench SHALL cover: rst_n low during ACTIVE -> grant=0 without waiting for a clock edge; request accepted on the first edge after release.
REQ-041 Bench SHALL cover: GUARD=0, HOLD=1, req_valid held high -> grants on alternating cycles, never back-to-back.
